// File: rtl/regfile_cmd_ctrl.sv
// rtl/regfile_cmd_ctrl.sv - command sequencer driving the 8x4 register file port set (optional RFCTL_WRITE_VERIFY_EN)
module regfile_cmd_ctrl #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          rf_load,
    output logic          rf_clr,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_din,
    input  logic [DW-1:0] rf_q
`ifdef RFCTL_WRITE_VERIFY_EN
    ,
    output logic          verify_err
`endif
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

`ifdef RFCTL_WRITE_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_RSP, S_FILL, S_CLR, S_WV
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_RSP, S_FILL, S_CLR
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] idx_inc;
    logic          rf_load_q, rf_load_d;
    logic          rf_clr_q, rf_clr_d;
    logic [AW-1:0] rf_addr_q, rf_addr_d;
    logic [DW-1:0] rf_din_q, rf_din_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
`ifdef RFCTL_WRITE_VERIFY_EN
    logic          verify_err_q, verify_err_d;
`endif

    assign idx_inc = idx_q + AW'(1);

    // Handshake/status decode straight from state so cmd_ready is valid the cycle after reset.
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

    assign rf_load   = rf_load_q;
    assign rf_clr    = rf_clr_q;
    assign rf_addr   = rf_addr_q;
    assign rf_din    = rf_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`ifdef RFCTL_WRITE_VERIFY_EN
    assign verify_err = verify_err_q;
`endif

    // Next-state and next-output logic; rf_* are computed for the state being entered so they line up with it.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        idx_d       = idx_q;
        rf_load_d   = 1'b0;
        rf_clr_d    = 1'b0;
        rf_addr_d   = rf_addr_q;
        rf_din_d    = rf_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef RFCTL_WRITE_VERIFY_EN
        verify_err_d = verify_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    data_d = cmd_data;
                    case (cmd_op)
                        OP_WRITE: begin
                            state_d   = S_WR;
                            rf_load_d = 1'b1;
                            rf_addr_d = cmd_addr;
                            rf_din_d  = cmd_data;
                        end
                        OP_READ: begin
                            state_d   = S_RD;
                            rf_addr_d = cmd_addr;
                        end
                        OP_FILL: begin
                            state_d   = S_FILL;
                            idx_d     = '0;
                            rf_load_d = 1'b1;
                            rf_addr_d = '0;
                            rf_din_d  = cmd_data;
                        end
                        OP_CLEAR: begin
                            state_d  = S_CLR;
                            rf_clr_d = 1'b1;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
`ifdef RFCTL_WRITE_VERIFY_EN
                // rf_addr still points at the written entry, so WV sees it on rf_q.
                state_d = S_WV;
`else
                state_d = S_IDLE;
`endif
            end
`ifdef RFCTL_WRITE_VERIFY_EN
            S_WV: begin
                if (rf_q != data_q) begin
                    verify_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
`endif
            S_RD: begin
                rsp_data_d  = rf_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_FILL: begin
                if (idx_q == {AW{1'b1}}) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d     = idx_inc;
                    rf_load_d = 1'b1;
                    rf_addr_d = idx_inc;
                    rf_din_d  = data_q + DW'(idx_inc);
                end
            end
            S_CLR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation and drops a pending response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            idx_q       <= '0;
            rf_load_q   <= 1'b0;
            rf_clr_q    <= 1'b0;
            rf_addr_q   <= '0;
            rf_din_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef RFCTL_WRITE_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            rf_load_q   <= rf_load_d;
            rf_clr_q    <= rf_clr_d;
            rf_addr_q   <= rf_addr_d;
            rf_din_q    <= rf_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef RFCTL_WRITE_VERIFY_EN
            verify_err_q <= verify_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// tb/tb_regfile_cmd_ctrl.sv - directed self-checking bench for regfile_cmd_ctrl with a behavioural 8x4 regfile
module tb_regfile_cmd_ctrl;
    localparam int DW = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic          rf_load;
    logic          rf_clr;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_q;
    logic          force_off;
`ifdef RFCTL_WRITE_VERIFY_EN
    logic          verify_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_cmd_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .rf_load   (rf_load),
        .rf_clr    (rf_clr),
        .rf_addr   (rf_addr),
        .rf_din    (rf_din),
        .rf_q      (rf_q)
`ifdef RFCTL_WRITE_VERIFY_EN
        ,
        .verify_err(verify_err)
`endif
    );

    // Behavioural register file; force_off blocks loads to provoke a verify mismatch.
    logic [DW-1:0] mem [8];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int k = 0; k < 8; k++) mem[k] <= '0;
        end else if (rf_load && !force_off) begin
            mem[rf_addr] <= rf_din;
        end
    end
    assign rf_q = mem[rf_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a command and return at the negedge right after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic accepted;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("send_accept", {31'd0, accepted}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        logic seen;
        seen      = 1'b0;
        rsp_ready = 1'b1;
        send(2'b01, a, '0);
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("read_rsp_seen", {31'd0, seen}, 32'd1);
        d = rsp_data;
        @(negedge clk);
    endtask

    logic [DW-1:0] rd;
    logic [DW-1:0] exp_fill [8];

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        force_off = 1'b0;

        // 1: reset held 3 cycles, then released
        step(); step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_rf_load", {31'd0, rf_load}, 32'd0);
        chk("rst_rf_clr", {31'd0, rf_clr}, 32'd0);
        chk("rst_rf_addr", {29'd0, rf_addr}, 32'd0);
        chk("rst_rf_din", {28'd0, rf_din}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {28'd0, rsp_data}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // 2: write 5 <- A, then read 5
        send(2'b00, 3'd5, 4'hA);
        chk("wr_load", {31'd0, rf_load}, 32'd1);
        chk("wr_addr", {29'd0, rf_addr}, 32'd5);
        chk("wr_din", {28'd0, rf_din}, 32'hA);
        step();
        chk("wr_load_pulse", {31'd0, rf_load}, 32'd0);
`ifdef RFCTL_WRITE_VERIFY_EN
        step();
        chk("wv_no_err", {31'd0, verify_err}, 32'd0);
`endif
        send(2'b01, 3'd5, 4'h0);
        chk("rd_addr", {29'd0, rf_addr}, 32'd5);
        chk("rd_rsp_not_yet", {31'd0, rsp_valid}, 32'd0);
        chk("rd_no_load", {31'd0, rf_load}, 32'd0);
        step();
        chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_rsp_data", {28'd0, rsp_data}, 32'hA);
        step();
        chk("rd_rsp_done", {31'd0, rsp_valid}, 32'd0);
        chk("rd_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // 3: fill seed E
        exp_fill = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        send(2'b10, 3'd0, 4'hE);
        for (int i = 0; i < 8; i++) begin
            chk("fill_load", {31'd0, rf_load}, 32'd1);
            chk("fill_addr", {29'd0, rf_addr}, i);
            chk("fill_din", {28'd0, rf_din}, {28'd0, exp_fill[i]});
            step();
        end
        chk("fill_end_load", {31'd0, rf_load}, 32'd0);
        chk("fill_end_ready", {31'd0, cmd_ready}, 32'd1);
        do_read(3'd1, rd);
        chk("fill_rd1", {28'd0, rd}, 32'hF);
        do_read(3'd7, rd);
        chk("fill_rd7", {28'd0, rd}, 32'h5);

        // 4: clear after fill
        send(2'b11, 3'd0, 4'h0);
        chk("clr_pulse", {31'd0, rf_clr}, 32'd1);
        chk("clr_no_load", {31'd0, rf_load}, 32'd0);
        step();
        chk("clr_pulse_end", {31'd0, rf_clr}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            do_read(AW'(i), rd);
            chk("clr_rd", {28'd0, rd}, 32'd0);
        end

        // 5: response stall with a second command waiting
        send(2'b00, 3'd2, 4'h9);
        step();
`ifdef RFCTL_WRITE_VERIFY_EN
        step();
`endif
        rsp_ready = 1'b0;
        send(2'b01, 3'd2, 4'h0);
        step();
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_addr  = 3'd3;
        cmd_data  = 4'h6;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_data", {28'd0, rsp_data}, 32'h9);
            chk("stall_ready", {31'd0, cmd_ready}, 32'd0);
            chk("stall_no_load", {31'd0, rf_load}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("stall_rsp_done", {31'd0, rsp_valid}, 32'd0);
        chk("stall_idle", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("post_stall_load", {31'd0, rf_load}, 32'd1);
        chk("post_stall_addr", {29'd0, rf_addr}, 32'd3);
        chk("post_stall_din", {28'd0, rf_din}, 32'h6);
        step();
`ifdef RFCTL_WRITE_VERIFY_EN
        step();
`endif

        // 6: reset during fill; addr 2 is the last entry written
        send(2'b10, 3'd0, 4'h7);
        step(); step();
        chk("fill2_addr", {29'd0, rf_addr}, 32'd2);
        rst_n = 1'b0;
        step();
        chk("mid_rst_load", {31'd0, rf_load}, 32'd0);
        chk("mid_rst_addr", {29'd0, rf_addr}, 32'd0);
        chk("mid_rst_din", {28'd0, rf_din}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        do_read(3'd0, rd);
        chk("part_rd0", {28'd0, rd}, 32'h7);
        do_read(3'd1, rd);
        chk("part_rd1", {28'd0, rd}, 32'h8);
        do_read(3'd2, rd);
        chk("part_rd2", {28'd0, rd}, 32'h9);
        do_read(3'd3, rd);
        chk("part_rd3", {28'd0, rd}, 32'h6);
        do_read(3'd7, rd);
        chk("part_rd7", {28'd0, rd}, 32'h0);

`ifdef RFCTL_WRITE_VERIFY_EN
        force_off = 1'b1;
        send(2'b00, 3'd4, 4'h3);
        step(); step();
        force_off = 1'b0;
        chk("verify_err_set", {31'd0, verify_err}, 32'd1);
        step(); step();
        chk("verify_err_sticky", {31'd0, verify_err}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("verify_err_rst", {31'd0, verify_err}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
